// File: rtl/cipher_pkg.sv
// rtl/cipher_pkg.sv - shared constants, S-box and state type for the 80-bit key schedule
package cipher_pkg;

  localparam int KEY_SIZE   = 80;
  localparam int BLOCK_SIZE = 64;
  localparam int NUM_ROUNDS = 31;
  localparam int CNT_BITS   = 5;

  localparam logic [3:0] SBOX [16] = '{
    4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
    4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
  };

  typedef enum logic {IDLE, RUN} state_t;

  function automatic logic [3:0] sbox4(input logic [3:0] nibble);
    return SBOX[nibble];
  endfunction

endpackage

// File: rtl/present_key_sequencer_if.sv
// rtl/present_key_sequencer_if.sv - start/key request and round-key handshake bundle
interface present_key_sequencer_if;
  import cipher_pkg::*;

  logic                  start;
  logic [KEY_SIZE-1:0]   key_in;
  logic                  rk_valid;
  logic                  rk_ready;
  logic [BLOCK_SIZE-1:0] round_key;
  logic [CNT_BITS-1:0]   round_idx;
  logic                  last;
  logic                  busy;
  logic                  done;

  modport master (
    input  start, key_in, rk_ready,
    output rk_valid, round_key, round_idx, last, busy, done
  );

  modport slave (
    output start, key_in, rk_ready,
    input  rk_valid, round_key, round_idx, last, busy, done
  );

endinterface

// File: rtl/present_key_update.sv
// rtl/present_key_update.sv - one round of the key register update (rotate, S-box, counter xor)
module present_key_update
  import cipher_pkg::*;
(
  input  logic [KEY_SIZE-1:0] key,
  input  logic [CNT_BITS-1:0] cnt,
  output logic [KEY_SIZE-1:0] next_key
);

  logic [KEY_SIZE-1:0] rotated;

  // Left rotation by 61 is the same as right rotation by 19.
  assign rotated = {key[18:0], key[79:19]};

  always_comb begin
    next_key          = rotated;
    next_key[79:76]   = sbox4(rotated[79:76]);
    next_key[19:15]   = rotated[19:15] ^ cnt;
  end

endmodule

// File: rtl/present_key_sequencer.sv
// rtl/present_key_sequencer.sv - emits round keys K1..K32 from a latched master key
module present_key_sequencer
  import cipher_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  present_key_sequencer_if.master   bus
);

  localparam logic [CNT_BITS:0] LAST_CNT = (CNT_BITS + 1)'(NUM_ROUNDS + 1);
  localparam logic [CNT_BITS:0] CNT_ONE  = (CNT_BITS + 1)'(1);

  state_t              state, state_nx;
  logic [KEY_SIZE-1:0] key_reg, key_nx, key_upd;
  logic [CNT_BITS:0]   cnt, cnt_nx;
  logic                done_q, done_nx;
  logic                xfer;
  logic                final_key;

  present_key_update u_update (
    .key      (key_reg),
    .cnt      (cnt[CNT_BITS-1:0]),
    .next_key (key_upd)
  );

  // cnt carries one extra bit so K32 (idx wraps to 0) is still distinguishable.
  assign final_key = (cnt == LAST_CNT);
  assign xfer      = (state == RUN) && bus.rk_ready;

  always_comb begin
    state_nx = state;
    key_nx   = key_reg;
    cnt_nx   = cnt;
    done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          key_nx   = bus.key_in;
          cnt_nx   = CNT_ONE;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (xfer) begin
          if (final_key) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end else begin
            key_nx = key_upd;
            cnt_nx = cnt + CNT_ONE;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      key_reg <= '0;
      cnt     <= '0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_nx;
      key_reg <= key_nx;
      cnt     <= cnt_nx;
      done_q  <= done_nx;
    end
  end

  assign bus.rk_valid  = (state == RUN);
  assign bus.busy      = (state == RUN);
  assign bus.round_key = key_reg[KEY_SIZE-1:KEY_SIZE-BLOCK_SIZE];
  assign bus.round_idx = cnt[CNT_BITS-1:0];
  assign bus.last      = (state == RUN) && final_key;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_present_key_sequencer.sv
// tb/tb_present_key_sequencer.sv - directed self-checking bench for present_key_sequencer
module tb_present_key_sequencer;
  import cipher_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  present_key_sequencer_if bus();

  present_key_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] keys [$];

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_s(input logic [3:0] n);
    case (n)
      4'h0: return 4'hC;  4'h1: return 4'h5;  4'h2: return 4'h6;  4'h3: return 4'hB;
      4'h4: return 4'h9;  4'h5: return 4'h0;  4'h6: return 4'hA;  4'h7: return 4'hD;
      4'h8: return 4'h3;  4'h9: return 4'hE;  4'hA: return 4'hF;  4'hB: return 4'h8;
      4'hC: return 4'h4;  4'hD: return 4'h7;  4'hE: return 4'h1;  default: return 4'h2;
    endcase
  endfunction

  function automatic logic [79:0] ref_update(input logic [79:0] k, input logic [5:0] c);
    logic [79:0] r;
    for (int i = 0; i < 80; i++) r[(i + 61) % 80] = k[i];
    r[79:76] = ref_s(r[79:76]);
    r[19:15] = r[19:15] ^ c[4:0];
    return r;
  endfunction

  function automatic logic [72:0] all_outs();
    return {bus.rk_valid, bus.busy, bus.done, bus.last, bus.round_idx, bus.round_key};
  endfunction

  task automatic do_start(input logic [79:0] key);
    bus.key_in = key;
    bus.start  = 1'b1;
    @(negedge clk);
    bus.start  = 1'b0;
  endtask

  // Called at a negedge with the DUT already in RUN; returns at the done negedge.
  task automatic stream(input logic [79:0] key, input bit rnd, input bit hold,
                        input bit inject, input int abort_at);
    logic [79:0] mk;
    logic [5:0]  idx;
    logic [63:0] prev;
    int xfers;
    bit fin, took, stalled;
    mk = key; idx = 6'd1; xfers = 0; fin = 0; stalled = 0; prev = '0;
    keys.delete();
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      if (xfers == abort_at) begin
        reset = 1'b0;
        bus.start = 1'b0;
        @(negedge clk);
        check("abort_clear", 80'(all_outs()), 80'd0);
        reset = 1'b1;
        @(negedge clk);
        check("abort_no_done", 80'({bus.done, bus.rk_valid}), 80'd0);
        check("abort_xfers", 80'(xfers), 80'(abort_at));
        return;
      end
      check("valid_busy", 80'({bus.rk_valid, bus.busy, bus.done}), 80'(3'b110));
      check("round_key", 80'(bus.round_key), 80'(mk[79:16]));
      check("round_idx", 80'(bus.round_idx), 80'(idx[4:0]));
      check("last", 80'(bus.last), 80'(idx == 6'd32));
      if (stalled) check("stall_hold", 80'(bus.round_key), 80'(prev));
      bus.rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      bus.start    = hold || (inject && (xfers == 9 || idx == 6'd32));
      bus.key_in   = (hold || inject) ? '1 : key;
      prev = bus.round_key;
      took = bus.rk_ready;
      @(negedge clk);
      stalled = !took;
      if (took) begin
        keys.push_back(prev);
        xfers++;
        if (idx == 6'd32) fin = 1;
        else begin
          mk  = ref_update(mk, idx);
          idx = idx + 6'd1;
        end
      end
    end
    check("transfers", 80'(xfers), 80'd32);
    check("done_pulse", 80'({bus.done, bus.busy, bus.rk_valid}), 80'(3'b100));
    if (!hold) bus.start = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    @(negedge clk);
    check(tag, 80'({bus.rk_valid, bus.busy, bus.done}), 80'd0);
  endtask

  initial begin
    bus.start    = 1'b1;
    bus.key_in   = '1;
    bus.rk_ready = 1'b0;
    reset        = 1'b0;

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_outputs", 80'(all_outs()), 80'd0);
    end
    reset = 1'b1;
    bus.start = 1'b0;
    for (int i = 0; i < 3; i++) check_idle("post_reset_idle");

    // Zero key, ready always high.
    do_start(80'd0);
    stream(80'd0, 1'b0, 1'b0, 1'b0, -1);
    check("zero_k1", 80'(keys[0]), 80'h0000000000000000);
    check("zero_k2", 80'(keys[1]), 80'hC000000000000000);
    check("zero_k3", 80'(keys[2]), 80'h5000180000000001);
    check_idle("zero_done_once");

    // Same key under random backpressure.
    do_start(80'd0);
    stream(80'd0, 1'b1, 1'b0, 1'b0, -1);
    check("bp_k2", 80'(keys[1]), 80'hC000000000000000);
    check("bp_k3", 80'(keys[2]), 80'h5000180000000001);
    check_idle("bp_done_once");

    // start pulses with an all-ones key while busy must be ignored.
    do_start(80'd0);
    stream(80'd0, 1'b0, 1'b0, 1'b1, -1);
    check("inject_k3", 80'(keys[2]), 80'h5000180000000001);
    check_idle("inject_no_restart");

    // start held high: second schedule starts right after done.
    bus.key_in = '1;
    bus.start  = 1'b1;
    @(negedge clk);
    stream({80{1'b1}}, 1'b0, 1'b1, 1'b0, -1);
    check("b2b1_k1", 80'(keys[0]), 80'hFFFFFFFFFFFFFFFF);
    check("b2b1_k2", 80'(keys[1]), 80'h2FFFFFFFFFFFFFFF);
    @(negedge clk);
    stream({80{1'b1}}, 1'b0, 1'b1, 1'b0, -1);
    check("b2b2_k1", 80'(keys[0]), 80'hFFFFFFFFFFFFFFFF);
    check("b2b2_k2", 80'(keys[1]), 80'h2FFFFFFFFFFFFFFF);
    bus.start = 1'b0;
    check_idle("b2b_stop");

    // Reset during the run, then a fresh start.
    do_start(80'h0123456789ABCDEF4567);
    stream(80'h0123456789ABCDEF4567, 1'b0, 1'b0, 1'b0, 15);
    do_start(80'h13579BDF02468ACE1122);
    check("restart_k1", 80'(bus.round_key), 80'h13579BDF02468ACE);
    check("restart_idx", 80'(bus.round_idx), 80'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
